cpu_trace_capture: RTL and testbench
====================================

Name: cpu_trace_capture

Overview:
Synthesizable retirement/trace monitor that sits beside the CPU inside the CPU/dmem/accelerator wrapper. It timestamps register-write, memory-read, memory-write and halt events into a trace FIFO. It also keeps cycle and instruction counters, detects halt, and enforces a watchdog cycle limit. Trace records drain through a valid/ready port to a host/debug bus, so capture works on silicon as well as in simulation.

Parameters:
DATA_W, 16, register/memory data width
ADDR_W, 16, memory address / PC width
REG_IDX_W, 4, register index width (must be <= ADDR_W)
FIFO_DEPTH, 16, trace FIFO entries, power of 2, >= 2
CYC_W, 32, cycle/instruction/drop counter width
WDOG_LIMIT, 200, RUN-cycle limit before TIMEOUT; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  IDLE->RUN request
clear  in  1  synchronous soft clear: FIFO, counters, state->IDLE
pc  in  ADDR_W  PC of the halting instruction
reg_wr  in  1  register-file write this cycle
reg_idx  in  REG_IDX_W  register written
reg_data  in  DATA_W  register write data
mem_rd  in  1  data-memory read this cycle
mem_wr  in  1  data-memory write this cycle
mem_addr  in  ADDR_W  data-memory address
mem_wdata  in  DATA_W  data to memory
mem_rdata  in  DATA_W  data from memory
halt  in  1  halt reached MEM/WB
trace_valid  out  1  record available
trace_ready  in  1  consumer accepts record
trace_kind  out  2  0 REG, 1 LOAD, 2 STORE, 3 HALT
trace_cycle  out  CYC_W  cycle stamp
trace_addr  out  ADDR_W  reg_idx (zero-extended) / mem_addr / pc
trace_data  out  DATA_W  reg_data / mem_rdata / mem_wdata / 0 for HALT
cycle_count  out  CYC_W  RUN cycles elapsed
inst_count  out  CYC_W  retired instructions
drop_count  out  CYC_W  events not recorded
state  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
proto_err  out  1  sticky: mem_rd and mem_wr asserted together

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all counters 0; FIFO empty; trace_valid=0; trace_* outputs 0; proto_err=0.
- clear has the same effect as reset, has priority over every other input, and can be asserted in any state.
- FSM transitions:
  - IDLE->RUN on start=1. Events in IDLE, including the start cycle, are ignored.
  - RUN->HALTED on halt=1.
  - RUN->TIMEOUT when WDOG_LIMIT!=0, cycle_count==WDOG_LIMIT-1 and halt=0. If halt and the limit coincide, HALTED wins.
  - HALTED and TIMEOUT are sticky until clear/reset. start is ignored outside IDLE.
- Counters:
  - In RUN, cycle_count increments once per cycle and saturates at all-ones.
  - inst_count increments when halt|reg_wr|mem_wr; it saturates.
  - Both counters freeze outside RUN.
- Event sampling happens only in RUN, with stamp = cycle_count value in that cycle (first RUN cycle stamps 0).
  - At most one record is pushed per cycle, priority HALT > STORE > LOAD > REG.
  - Each lower-priority simultaneous event increments drop_count by 1.
  - If mem_rd&mem_wr, STORE is taken, the LOAD is dropped and proto_err is set.
- FIFO:
  - A record pushed at cycle N gives trace_valid=1 at N+1 (registered outputs, first-word-fall-through).
  - Pop occurs on trace_valid&trace_ready.
  - A push when full is dropped (drop_count++, saturating) unless a pop occurs the same cycle, in which case it is accepted.
  - Read/write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished with an extra pointer bit.
- The FIFO keeps draining in HALTED/TIMEOUT/IDLE. Only clear/reset empties it.
- trace_* outputs are held stable while trace_valid=1 and trace_ready=0.

Decomposition:
- Package cpu_trace_pkg holds:
  - trace_kind_e (REG/LOAD/STORE/HALT)
  - trace_state_e (IDLE/RUN/HALTED/TIMEOUT)
  - the packed trace_rec_t struct {kind, cycle, addr, data}, sized from the package's default widths; the top repacks for overridden parameters.
- Sub-module cpu_trace_fifo: a parametrised FWFT synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty and simultaneous push-pop-when-full support. The FSM, counters and arbitration stay in the top.

Test Plan:
- Reset, start, then reg_wr idx 3 data 0x00AB on RUN cycle 2 (stamp 2) -> next cycle trace_valid=1, kind 0, cycle 2, addr 0x0003, data 0x00AB; inst_count=1.
- Same cycle reg_wr and mem_wr addr 0x0040 data 0x1234 -> one STORE record, drop_count=1, inst_count+=1; next cycle mem_rd&mem_wr -> STORE recorded, drop_count=2, proto_err=1.
- trace_ready=0, 20 consecutive reg_wr (DEPTH 16) -> 16 records held, drop_count=4; then ready=1 while reg_wr continues -> no further drops, records drained in order.
- halt with pc 0x001C at RUN cycle 50 -> HALT record {3, 50, 0x001C, 0}; state=2; cycle_count frozen at 51.
- No halt, WDOG_LIMIT=200 -> state=3 after RUN cycle 199; cycle_count=200; later halt ignored.
- clear asserted in RUN with 5 records queued -> next cycle state=IDLE, trace_valid=0, all counters 0; start restarts capture.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace monitor: record kinds, monitor states and the
// default-width trace record layout.
package cpu_trace_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CYC_W  = 32;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } trace_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } trace_state_e;

  typedef struct packed {
    trace_kind_e           kind;
    logic [DEF_CYC_W-1:0]  cycle;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Trace record drain port: the monitor (master) offers records, the host/debug
// bus (slave) accepts them with trace_ready.
interface cpu_trace_capture_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CYC_W  = 32
);
  logic              trace_valid;
  logic              trace_ready;
  logic [1:0]        trace_kind;
  logic [CYC_W-1:0]  trace_cycle;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;

  modport master (
    output trace_valid, trace_kind, trace_cycle, trace_addr, trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_kind, trace_cycle, trace_addr, trace_data,
    output trace_ready
  );
endinterface

// File: rtl/cpu_trace_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO for trace records.
// Latency: a word pushed at cycle N is visible on pop_data at N+1.
// Backpressure: push while full is refused unless a pop frees a slot that cycle.
module cpu_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra MSB on the pointers tells full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/cpu_trace_capture.sv
// Purpose: CPU retirement monitor; stamps reg/load/store/halt events into a trace FIFO, keeps counters and a watchdog.
// Latency: an event sampled at RUN cycle N appears on the trace port at N+1.
// Backpressure: trace_ready=0 holds the head record; events arriving with the FIFO full are counted as drops.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_IDX_W  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CYC_W      = 32,
  parameter int WDOG_LIMIT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [ADDR_W-1:0]    pc,
  input  logic                 reg_wr,
  input  logic [REG_IDX_W-1:0] reg_idx,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 halt,
  cpu_trace_capture_if.master  trace,
  output logic [CYC_W-1:0]     cycle_count,
  output logic [CYC_W-1:0]     inst_count,
  output logic [CYC_W-1:0]     drop_count,
  output logic [1:0]           state,
  output logic                 proto_err
);
  localparam int REC_W = 2 + CYC_W + ADDR_W + DATA_W;

  trace_state_e st_q;
  logic         run;
  logic         ev_halt, ev_store, ev_load, ev_reg;
  logic [2:0]   n_ev;
  logic         push;
  trace_kind_e  push_kind;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [REC_W-1:0]  rec_in, rec_out;
  logic         fifo_full, fifo_empty, pop, fifo_drop;
  logic [2:0]   drop_inc;
  logic [CYC_W:0] drop_sum;
  logic         wdog_hit;

  assign run      = (st_q == ST_RUN);
  assign state    = st_q;
  assign ev_halt  = run & halt;
  assign ev_store = run & mem_wr;
  assign ev_load  = run & mem_rd;
  assign ev_reg   = run & reg_wr;
  assign n_ev     = {2'b0, ev_halt} + {2'b0, ev_store} + {2'b0, ev_load} + {2'b0, ev_reg};
  assign push     = ev_halt | ev_store | ev_load | ev_reg;

  // Only the highest-priority event of the cycle is recorded.
  always_comb begin
    push_kind = KIND_REG;
    push_addr = ADDR_W'(reg_idx);
    push_data = reg_data;
    if (halt) begin
      push_kind = KIND_HALT;
      push_addr = pc;
      push_data = '0;
    end else if (mem_wr) begin
      push_kind = KIND_STORE;
      push_addr = mem_addr;
      push_data = mem_wdata;
    end else if (mem_rd) begin
      push_kind = KIND_LOAD;
      push_addr = mem_addr;
      push_data = mem_rdata;
    end
  end

  assign rec_in = {push_kind, cycle_count, push_addr, push_data};

  cpu_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clear),
    .push      (push),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (rec_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop       = ~fifo_empty & trace.trace_ready;
  assign fifo_drop = push & fifo_full & ~pop;
  assign drop_inc  = (push ? n_ev - 3'd1 : 3'd0) + {2'b0, fifo_drop};
  assign drop_sum  = {1'b0, drop_count} + (CYC_W+1)'(drop_inc);
  assign wdog_hit  = (WDOG_LIMIT != 0) && (cycle_count == CYC_W'(WDOG_LIMIT - 1));

  // Fields read as zero whenever no record is offered.
  assign trace.trace_valid = ~fifo_empty;
  assign trace.trace_kind  = fifo_empty ? '0 : rec_out[REC_W-1 -: 2];
  assign trace.trace_cycle = fifo_empty ? '0 : rec_out[ADDR_W+DATA_W +: CYC_W];
  assign trace.trace_addr  = fifo_empty ? '0 : rec_out[DATA_W +: ADDR_W];
  assign trace.trace_data  = fifo_empty ? '0 : rec_out[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      st_q        <= ST_IDLE;
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      proto_err   <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: if (start) st_q <= ST_RUN;
        ST_RUN: begin
          if (halt)          st_q <= ST_HALTED;
          else if (wdog_hit) st_q <= ST_TIMEOUT;
        end
        default: ;
      endcase
      if (run) begin
        if (~&cycle_count) cycle_count <= cycle_count + CYC_W'(1);
        if ((halt | reg_wr | mem_wr) && ~&inst_count) inst_count <= inst_count + CYC_W'(1);
        if (mem_rd & mem_wr) proto_err <= 1'b1;
      end
      drop_count <= drop_sum[CYC_W] ? '1 : drop_sum[CYC_W-1:0];
    end
  end
endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: directed scenarios plus random traffic, every
// cycle compared with a queue-based reference model of the monitor.
module tb_cpu_trace_capture;
  import cpu_trace_pkg::*;

  localparam int DATA_W = 16, ADDR_W = 16, REG_IDX_W = 4, DEPTH = 16, CYC_W = 32, WDOG = 200;
  localparam longint CMAX = (64'd1 << CYC_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, clear, reg_wr, mem_rd, mem_wr, halt;
  logic [ADDR_W-1:0]    pc, mem_addr;
  logic [REG_IDX_W-1:0] reg_idx;
  logic [DATA_W-1:0]    reg_data, mem_wdata, mem_rdata;
  logic [CYC_W-1:0]     cycle_count, inst_count, drop_count;
  logic [1:0]           state;
  logic                 proto_err;

  cpu_trace_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) trc();

  cpu_trace_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W),
    .FIFO_DEPTH(DEPTH), .CYC_W(CYC_W), .WDOG_LIMIT(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .pc(pc),
    .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .trace(trc), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .state(state), .proto_err(proto_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: monitor state, counters and the queue of stored records.
  int         m_state;
  longint     m_cyc, m_inst, m_drop;
  bit         m_proto;
  trace_rec_t q[$];

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_edge();
    trace_rec_t r;
    int n;
    int drops;
    bit pop;
    if (!rst_n || clear) begin
      m_state = 0; m_cyc = 0; m_inst = 0; m_drop = 0; m_proto = 0;
      q.delete();
      return;
    end
    pop   = (q.size() > 0) && trc.trace_ready;
    n     = 0;
    drops = 0;
    r     = '0;
    if (m_state == 1) begin
      n = int'(halt) + int'(mem_wr) + int'(mem_rd) + int'(reg_wr);
      r.cycle = m_cyc[CYC_W-1:0];
      if (halt)        begin r.kind = KIND_HALT;  r.addr = pc;             r.data = '0;        end
      else if (mem_wr) begin r.kind = KIND_STORE; r.addr = mem_addr;       r.data = mem_wdata; end
      else if (mem_rd) begin r.kind = KIND_LOAD;  r.addr = mem_addr;       r.data = mem_rdata; end
      else             begin r.kind = KIND_REG;   r.addr = 16'(reg_idx);   r.data = reg_data;  end
      if (n > 1) drops = n - 1;
      if (mem_rd && mem_wr) m_proto = 1;
      if (halt || reg_wr || mem_wr) m_inst = sat(m_inst + 1);
      if (halt) m_state = 2;
      else if (WDOG != 0 && m_cyc == WDOG - 1) m_state = 3;
      m_cyc = sat(m_cyc + 1);
    end else if (m_state == 0 && start) begin
      m_state = 1;
    end
    if (pop) void'(q.pop_front());
    if (n > 0) begin
      if (q.size() < DEPTH) q.push_back(r);
      else drops++;
    end
    m_drop = sat(m_drop + drops);
  endtask

  task automatic check_outputs();
    trace_rec_t h;
    check_eq("state", state, m_state);
    check_eq("cycle_count", cycle_count, m_cyc);
    check_eq("inst_count", inst_count, m_inst);
    check_eq("drop_count", drop_count, m_drop);
    check_eq("proto_err", proto_err, m_proto);
    check_eq("trace_valid", trc.trace_valid, q.size() > 0);
    h = (q.size() > 0) ? q[0] : '0;
    check_eq("trace_kind", trc.trace_kind, h.kind);
    check_eq("trace_cycle", trc.trace_cycle, h.cycle);
    check_eq("trace_addr", trc.trace_addr, h.addr);
    check_eq("trace_data", trc.trace_data, h.data);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    start = 0; clear = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0;
    pc = 16'($urandom); reg_idx = 4'($urandom); reg_data = 16'($urandom);
    mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
  endtask

  task automatic rand_events(input bit allow_halt);
    idle_in();
    reg_wr = ($urandom_range(0, 1) == 0);
    mem_rd = ($urandom_range(0, 3) == 0);
    mem_wr = ($urandom_range(0, 3) == 0);
    halt   = allow_halt && ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    trc.trace_ready = 0;
    step(); step();
    check_eq("rst_state", state, 0);
    check_eq("rst_valid", trc.trace_valid, 0);
    check_eq("rst_cycle_count", cycle_count, 0);
    rst_n = 1;

    // First register write at RUN stamp 2
    start = 1; step(); idle_in();
    step(); step();
    reg_wr = 1; reg_idx = 4'd3; reg_data = 16'h00AB; step(); idle_in();
    check_eq("reg_rec_valid", trc.trace_valid, 1);
    check_eq("reg_rec_kind", trc.trace_kind, 0);
    check_eq("reg_rec_cycle", trc.trace_cycle, 2);
    check_eq("reg_rec_addr", trc.trace_addr, 16'h0003);
    check_eq("reg_rec_data", trc.trace_data, 16'h00AB);
    check_eq("reg_rec_inst", inst_count, 1);

    // Simultaneous events and protocol error
    reg_wr = 1; mem_wr = 1; mem_addr = 16'h0040; mem_wdata = 16'h1234; step(); idle_in();
    check_eq("store_drop", drop_count, 1);
    check_eq("store_inst", inst_count, 2);
    mem_rd = 1; mem_wr = 1; step(); idle_in();
    check_eq("rdwr_drop", drop_count, 2);
    check_eq("rdwr_proto", proto_err, 1);

    // Drain, then overfill the FIFO, then stream at full occupancy
    trc.trace_ready = 1;
    repeat (3) step();
    trc.trace_ready = 0;
    for (int i = 0; i < 20; i++) begin
      idle_in(); reg_wr = 1; step();
    end
    check_eq("full_drop", drop_count, 6);
    trc.trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      idle_in(); reg_wr = 1; step();
    end
    check_eq("stream_drop", drop_count, 6);
    idle_in();

    // Halt at RUN stamp 50
    for (int i = 0; i < 100 && m_cyc != 50; i++) step();
    check_eq("halt_setup_cycle", cycle_count, 50);
    halt = 1; pc = 16'h001C; step(); idle_in();
    check_eq("halt_state", state, 2);
    check_eq("halt_cycle_frozen", cycle_count, 51);
    for (int i = 0; i < 40 && q.size() > 1; i++) step();
    check_eq("halt_rec_kind", trc.trace_kind, 3);
    check_eq("halt_rec_cycle", trc.trace_cycle, 50);
    check_eq("halt_rec_addr", trc.trace_addr, 16'h001C);
    check_eq("halt_rec_data", trc.trace_data, 0);
    for (int i = 0; i < 5; i++) begin
      rand_events(1); start = 1; step();
    end
    check_eq("halted_sticky", state, 2);
    check_eq("halted_cycle", cycle_count, 51);

    // Watchdog expiry
    idle_in(); clear = 1; step();
    idle_in(); start = 1; step();
    for (int i = 0; i < WDOG; i++) begin
      rand_events(0);
      trc.trace_ready = ($urandom_range(0, 1) == 0);
      step();
    end
    check_eq("wdog_state", state, 3);
    check_eq("wdog_cycle", cycle_count, 200);
    idle_in(); halt = 1; step();
    check_eq("wdog_halt_ignored", state, 3);
    check_eq("wdog_cycle_frozen", cycle_count, 200);

    // Clear with records queued, then restart
    idle_in(); clear = 1; step();
    idle_in(); start = 1; step();
    trc.trace_ready = 0;
    for (int i = 0; i < 5; i++) begin
      idle_in(); reg_wr = 1; step();
    end
    idle_in(); clear = 1; step();
    check_eq("clr_state", state, 0);
    check_eq("clr_valid", trc.trace_valid, 0);
    check_eq("clr_cycle", cycle_count, 0);
    check_eq("clr_inst", inst_count, 0);
    check_eq("clr_drop", drop_count, 0);
    idle_in(); start = 1; step();
    idle_in(); reg_wr = 1; step(); idle_in();
    check_eq("restart_valid", trc.trace_valid, 1);
    check_eq("restart_cycle", trc.trace_cycle, 0);

    // Random traffic including resets, clears, starts and halts
    for (int i = 0; i < 500; i++) begin
      rand_events(1);
      start = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      trc.trace_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1;
    idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
